// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle restoring radix-2 divider and sequencer for DIV/DIVU.
// Launches from an E-stage request, holds the pipeline while iterating and
// delivers quotient (lo) / remainder (hi) with a one-cycle result_valid pulse.
// Optional feature macro: DIV_EARLY_OUT_EN (zero divisor or zero dividend
// skips the iterations and finishes in the cycle after start).
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             cancel,
  output logic             stall,
  output logic             busy,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] lo_fin;
  logic [WIDTH-1:0] hi_fin;

  // Operand magnitudes; only a signed request treats the msb as a sign bit.
  always_comb begin
    abs_a = (signed_div && opa[WIDTH-1]) ? (~opa + 1'b1) : opa;
    abs_b = (signed_div && opb[WIDTH-1]) ? (~opb + 1'b1) : opb;
  end

  // One restoring step plus the sign-corrected results of the final step.
  // A zero divisor always "subtracts", so quo becomes all ones and rem ends
  // up as |opa|; re-applying the dividend sign restores the raw opa in hi.
  always_comb begin
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, dvsr};
    take    = (trial >= {1'b0, dvsr});
    rem_nxt = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], take};
    lo_fin  = dz ? '1 : (sign_q ? (~quo_nxt + 1'b1) : quo_nxt);
    hi_fin  = sign_r ? (~rem_nxt + 1'b1) : rem_nxt;
  end

  // Sequencer: capture on start, iterate WIDTH times, register results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      lo          <= '0;
      hi          <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            quo    <= abs_a;
            dvsr   <= abs_b;
            rem    <= '0;
            cnt    <= '0;
            sign_q <= signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            sign_r <= signed_div & opa[WIDTH-1];
            dz     <= (opb == '0);
`ifdef DIV_EARLY_OUT_EN
            if ((opb == '0) || (opa == '0)) begin
              state       <= DONE;
              lo          <= (opb == '0) ? '1 : '0;
              hi          <= (opb == '0) ? opa : '0;
              div_by_zero <= (opb == '0);
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          if (cancel) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == LAST) begin
              state       <= DONE;
              lo          <= lo_fin;
              hi          <= hi_fin;
              div_by_zero <= dz;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake outputs; stall drops in DONE so the instruction advances.
  always_comb begin
    busy         = (state != IDLE);
    stall        = ((state == IDLE) && start && !cancel) || (state == BUSY);
    result_valid = (state == DONE) && !cancel;
  end

endmodule
